shift_iter: RTL and testbench
=============================

# shift_iter

Multi-cycle iterative shifter: shifts or rotates a 16-bit operand by 0–15 positions, one bit per clock, under a start/done handshake. It implements the same four operations as the combinational barrel-shifter stages, so the two implementations can be cross-checked. It also serves as a low-area shift unit for the ALU's multi-cycle path.

## Interface
Parameters: none (width fixed at 16, count fixed at 4 bits).

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- in  in  16  operand; captured with start
- cnt  in  4  shift amount 0–15; captured with start
- op  in  2  operation; captured with start: 00 ROL, 01 SLL, 10 SRA, 11 SRL
- busy  out  1  high in every state other than IDLE
- done  out  1  one-cycle pulse; out is the final result in that cycle
- out  out  16  working/result register

## Operation
- Three states: IDLE, SHIFT and DONE.
- Internal registers:
  - work[15:0], drives out
  - rem[3:0], bits still to shift
  - op_q[1:0]
- IDLE:
  - If start=1: work←in, rem←cnt, op_q←op.
  - Next state is DONE if cnt==0, otherwise SHIFT.
  - If start=0: hold all registers.
- SHIFT, per edge: work←step(work, op_q), rem←rem−1.
  - Next state is DONE when rem==1 (last step), otherwise stay in SHIFT.
- step functions:
  - ROL: {w[14:0], w[15]}
  - SLL: {w[14:0], 1'b0}
  - SRA: {w[15], w[15:1]}
  - SRL: {1'b0, w[15:1]}
- DONE: done=1 for exactly this cycle. work holds. Next state is IDLE unconditionally.
- start is ignored while busy=1, including in the DONE cycle. in, cnt and op may change freely after capture.
- out is valid only when done=1 and afterwards, until the next accepted start. During SHIFT it shows intermediate values.
- out holds the last result indefinitely while in IDLE.
- Results must equal the combinational shifter for the same in/op/cnt.
- Reset (any state, including mid-SHIFT): state←IDLE, work←0, rem←0, op_q←00. busy=0, done=0, out=0 from the cycle after the reset edge. An in-flight operation is discarded with no done pulse.
- If rst and start are both high, rst wins and start is not captured.

## Timing
- Cycle 0 is the cycle in which start=1 is sampled in IDLE.
- busy=1 from cycle 1 through cycle cnt+1 inclusive.
- done=1 in cycle cnt+1 only: cnt=0 gives cycle 1, cnt=15 gives cycle 16.
- busy=0 again in cycle cnt+2. A new start may be sampled in that cycle, giving a throughput of one operation per cnt+2 cycles.
- Outputs are registered only, with no combinational path from inputs to outputs. done and busy decode the state register.

## Test plan
- Reset, then idle: rst=1 for 2 cycles → out=0x0000, busy=0, done=0. With start=0 thereafter, all outputs stay constant.
- ROL and zero count:
  - in=0x8001, op=00, cnt=4 → done in cycle 5, out=0x0018, busy high in cycles 1–5.
  - in=0x1234, cnt=0 → done in cycle 1, out=0x1234.
- Sign handling at maximum count:
  - in=0x8000, op=10, cnt=15 → done in cycle 16, out=0xFFFF.
  - Same with op=11 → out=0x0001.
  - Same with op=01 → out=0x0000.
- Equivalence with the barrel-shifter stage:
  - in=0x00FF, op=01, cnt=8 → 0xFF00.
  - in=0xABCD, op=00, cnt=8 → 0xCDAB.
  - in=0x8F00, op=10, cnt=8 → 0xFF8F.
  - in=0x8F00, op=11, cnt=8 → 0x008F.
  - Also compare against the combinational shifter over random in/op/cnt.
- Handshake:
  - Assert start continuously with changing in/cnt during an operation → only the first request is processed, and its result is unaffected.
  - The next start, held high, is accepted in cycle cnt+2.
- Reset mid-operation: start with cnt=10, assert rst in cycle 4 → next cycle busy=0, out=0, and no done pulse ever. A subsequent op completes normally.

Source files
------------

// File: rtl/shift_iter.sv
// shift_iter: iterative 16-bit shifter/rotator. It moves the operand one bit
// per clock under a start/done handshake. Its results match the combinational
// barrel-shifter for ROL, SLL, SRA and SRL.
module shift_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] in,
  input  logic [3:0]  cnt,
  input  logic [1:0]  op,
  output logic        busy,
  output logic        done,
  output logic [15:0] out
);

  localparam int DATA_W = 16;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   work;
  logic [3:0]          rem;
  logic [1:0]          op_q;

  // One single-bit move of the working value for the captured operation.
  function automatic logic [DATA_W-1:0] step(input logic [DATA_W-1:0] w,
                                             input logic [1:0]        o);
    logic signed [DATA_W-1:0] ws;
    logic [DATA_W-1:0]        r;
    ws = w;
    case (o)
      OP_ROL:  r = {w[DATA_W-2:0], w[DATA_W-1]};
      OP_SLL:  r = {w[DATA_W-2:0], 1'b0};
      OP_SRA:  r = ws >>> 1;
      default: r = {1'b0, w[DATA_W-1:1]};
    endcase
    return r;
  endfunction

  // Control FSM and datapath registers. Reset clears everything so that a
  // discarded operation leaves no trace on out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      work  <= '0;
      rem   <= '0;
      op_q  <= OP_ROL;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work  <= in;
            rem   <= cnt;
            op_q  <= op;
            state <= (cnt == 4'd0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          work <= step(work, op_q);
          rem  <= rem - 4'd1;
          if (rem == 4'd1) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Handshake outputs decode the state register only; there is no path from
  // inputs to outputs.
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
    out  = work;
  end

endmodule

// File: tb/tb_shift_iter.sv
// tb_shift_iter: directed and random vectors for shift_iter. A queue holds
// the expected result and done cycle of each accepted request. A monitor
// compares them on every done pulse.
module tb_shift_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] in;
  logic [3:0]  cnt;
  logic [1:0]  op;
  logic        busy;
  logic        done;
  logic [15:0] out;

  shift_iter dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in    (in),
    .cnt   (cnt),
    .op    (op),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] val;
    int          when;
    string       name;
  } exp_t;

  exp_t sb[$];
  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Reference: closed-form shift, independent of the one-bit-per-cycle walk.
  function automatic logic [15:0] model(input logic [15:0] x, input logic [3:0] c,
                                        input logic [1:0] o);
    logic [31:0]        d;
    logic signed [15:0] s;
    logic [15:0]        r;
    d = {x, x} << c;
    s = x;
    case (o)
      2'b00:   r = d[31:16];
      2'b01:   r = x << c;
      2'b10:   r = s >>> c;
      default: r = x >> c;
    endcase
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pulse", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_out"}, {16'h0, out}, {16'h0, e.val});
        chk({e.name, "_cycle"}, cyc, e.when);
      end
    end
  end

  // Present one request in cycle 0, then scramble the inputs from cycle 1 on.
  task automatic issue(input logic [15:0] i, input logic [3:0] c, input logic [1:0] o,
                       input bit expect_it, input string nm, input logic [15:0] res);
    @(negedge clk);
    start = 1'b1;
    in    = i;
    cnt   = c;
    op    = o;
    if (expect_it) sb.push_back('{res, cyc + int'(c) + 1, nm});
    @(negedge clk);
    start = 1'b0;
    in    = 16'($urandom);
    cnt   = 4'($urandom);
    op    = 2'($urandom);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_timeout"}, {31'h0, n >= 60}, 32'h0);
  endtask

  task automatic run(input logic [15:0] i, input logic [3:0] c, input logic [1:0] o,
                     input string nm, input logic [15:0] res);
    issue(i, c, o, 1'b1, nm, res);
    wait_idle(nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] ri;
    logic [3:0]  rc;
    logic [1:0]  ro;

    rst = 1'b1; start = 1'b0; in = '0; cnt = '0; op = '0;
    repeat (2) @(negedge clk);
    chk("rst_out", {16'h0, out}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_out", {16'h0, out}, 32'h0);
      chk("idle_busy", {31'h0, busy}, 32'h0);
    end

    // ROL by 4 with a per-cycle busy profile: high in cycles 1..5 only.
    issue(16'h8001, 4'd4, 2'b00, 1'b1, "rol4", 16'h0018);
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("rol4_busy_c%0d", k), {31'h0, busy}, {31'h0, k <= 5});
      @(negedge clk);
    end
    wait_idle("rol4");

    run(16'h1234, 4'd0,  2'b00, "cnt0",   16'h1234);
    run(16'h8000, 4'd15, 2'b10, "sra15",  16'hFFFF);
    run(16'h8000, 4'd15, 2'b11, "srl15",  16'h0001);
    run(16'h8000, 4'd15, 2'b01, "sll15",  16'h0000);
    run(16'h00FF, 4'd8,  2'b01, "sll8",   16'hFF00);
    run(16'hABCD, 4'd8,  2'b00, "rol8",   16'hCDAB);
    repeat (3) @(negedge clk);
    chk("hold_out", {16'h0, out}, {16'h0, 16'hCDAB});
    run(16'h8F00, 4'd8,  2'b10, "sra8",   16'hFF8F);
    run(16'h8F00, 4'd8,  2'b11, "srl8",   16'h008F);

    // start held high; the second request is only taken in cycle cnt+2.
    @(negedge clk);
    start = 1'b1; in = 16'h0F0F; cnt = 4'd3; op = 2'b11;
    sb.push_back('{16'h01E1, cyc + 4, "hs_first"});
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      in = 16'hA5A5 ^ 16'(k); cnt = 4'd15; op = 2'b00;
    end
    @(negedge clk);
    chk("hs_busy_c5", {31'h0, busy}, 32'h0);
    in = 16'h1234; cnt = 4'd2; op = 2'b01;
    sb.push_back('{16'h48D0, cyc + 3, "hs_second"});
    @(negedge clk);
    start = 1'b0; in = 16'hFFFF; cnt = 4'd9; op = 2'b10;
    wait_idle("hs");

    // Reset in cycle 4 of a cnt=10 op, with a competing start.
    issue(16'h1111, 4'd10, 2'b00, 1'b0, "abort", 16'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1; start = 1'b1; in = 16'hBEEF; cnt = 4'd0; op = 2'b00;
    @(negedge clk);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_out", {16'h0, out}, 32'h0);
    chk("abort_done", {31'h0, done}, 32'h0);
    rst = 1'b0; start = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_stay_idle", {31'h0, busy}, 32'h0);
    run(16'h8001, 4'd1, 2'b01, "after_abort", 16'h0002);

    for (int k = 0; k < 12; k++) begin
      ri = 16'($urandom);
      rc = 4'($urandom);
      ro = 2'($urandom);
      run(ri, rc, ro, $sformatf("rand%0d", k), model(ri, rc, ro));
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
